// File: rtl/aes_inv_key_schedule.sv
// Inverse AES-128 key schedule: loads round key NUM_ROUNDS and emits keys NUM_ROUNDS..0 over valid/ready, one per accepted cycle.
// Define AES_INV_KS_SBOX_REG_EN to register the SubWord output (adds a WAIT_SB bubble, one key per 2 cycles).
module aes_inv_key_schedule #(
  parameter int word_size  = 8,
  parameter int array_size = 16,
  parameter int NUM_ROUNDS = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [word_size*array_size-1:0]   key_in,
  input  logic                              key_ready,
  output logic [word_size*array_size-1:0]   round_key,
  output logic [3:0]                        round_idx,
  output logic                              key_valid,
  output logic                              busy,
  output logic                              done
);

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[8*(255-int'(x)) +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

`ifdef AES_INV_KS_SBOX_REG_EN
  typedef enum logic [1:0] {IDLE, PRESENT, WAIT_SB, DONE} state_t;
  logic [31:0] sb_reg;
`else
  typedef enum logic [1:0] {IDLE, PRESENT, DONE} state_t;
`endif

  state_t      state;
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] p1, p2, p3;
  logic [31:0] sub_rot;
  logic [31:0] rcon_word;

  assign w0 = round_key[31:0];
  assign w1 = round_key[63:32];
  assign w2 = round_key[95:64];
  assign w3 = round_key[127:96];
  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;

  // Byte 4j is the FIPS MSB of word j, so RotWord+SubWord maps p3 bytes (12,13,14,15) to (S13,S14,S15,S12).
  assign sub_rot   = {sbox(p3[7:0]), sbox(p3[31:24]), sbox(p3[23:16]), sbox(p3[15:8])};
  assign rcon_word = {24'h0, rcon(round_idx)};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      round_key <= '0;
      round_idx <= '0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef AES_INV_KS_SBOX_REG_EN
      sb_reg    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            round_key <= key_in;
            round_idx <= 4'(NUM_ROUNDS);
            key_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (key_valid && key_ready) begin
            if (round_idx == 4'd0) begin
              key_valid <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              round_idx <= round_idx - 4'd1;
`ifdef AES_INV_KS_SBOX_REG_EN
              // Word 0 is finished in WAIT_SB from the registered S-box result.
              round_key <= {p3, p2, p1, w0};
              sb_reg    <= sub_rot ^ rcon_word;
              key_valid <= 1'b0;
              state     <= WAIT_SB;
`else
              round_key <= {p3, p2, p1, w0 ^ sub_rot ^ rcon_word};
`endif
            end
          end
        end
`ifdef AES_INV_KS_SBOX_REG_EN
        WAIT_SB: begin
          round_key[31:0] <= w0 ^ sb_reg;
          key_valid       <= 1'b1;
          state           <= PRESENT;
        end
`endif
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Scoreboard bench: a word-level FIPS-197 model (S-box derived from GF(2^8) arithmetic) feeds a queue popped on each handshake.
module tb_aes_inv_key_schedule;

  typedef struct packed {
    logic [127:0] key;
    logic [3:0]   idx;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, start, key_ready;
  logic [127:0] key_in, round_key;
  logic [3:0]   round_idx;
  logic         key_valid, busy, done;

  aes_inv_key_schedule #(.word_size(8), .array_size(16), .NUM_ROUNDS(10)) dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .key_ready(key_ready),
    .round_key(round_key), .round_idx(round_idx), .key_valid(key_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

`ifdef AES_INV_KS_SBOX_REG_EN
  localparam bit NEXT_VLD = 1'b0;
`else
  localparam bit NEXT_VLD = 1'b1;
`endif

  int         checks = 0;
  int         errors = 0;
  int         done_count = 0;
  int         done_expected = 0;
  bit         rdy_rand = 1'b0;
  exp_t       q[$];
  logic [7:0] sb_ref [0:255];
  logic [31:0] wf [0:43];

  task automatic chk(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] exp_v);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp_v);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    logic [15:0] t;
    t = {b, b};
    return t[(15-k) -: 8];
  endfunction

  function automatic logic [127:0] fips2bus(input logic [127:0] f);
    logic [127:0] b;
    for (int k = 0; k < 16; k++) b[8*k +: 8] = f[127-8*k -: 8];
    return b;
  endfunction

  // Walk w[i-4] = w[i] ^ temp backwards from round 10, exactly as the FIPS recurrence reads.
  task automatic build_sched(input logic [127:0] kf);
    logic [31:0] t;
    logic [7:0]  rc;
    for (int j = 0; j < 4; j++) wf[40+j] = kf[127-32*j -: 32];
    for (int i = 43; i >= 4; i--) begin
      t = wf[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sb_ref[t[31:24]], sb_ref[t[23:16]], sb_ref[t[15:8]], sb_ref[t[7:0]]};
        rc = 8'h01;
        for (int k = 1; k < i/4; k++) rc = xtime(rc);
        t  = t ^ {rc, 24'h0};
      end
      wf[i-4] = wf[i] ^ t;
    end
  endtask

  task automatic start_seq(input logic [127:0] kf, input bit fips);
    exp_t e;
    build_sched(kf);
    for (int r = 10; r >= 0; r--) begin
      e.idx = 4'(r);
      e.key = fips2bus({wf[4*r], wf[4*r+1], wf[4*r+2], wf[4*r+3]});
      if (fips && r == 9) e.key = fips2bus(128'hac7766f319fadc2128d12941575c006e);
      if (fips && r == 0) e.key = fips2bus(128'h2b7e151628aed2a6abf7158809cf4f3c);
      q.push_back(e);
    end
    key_in = fips2bus(kf);
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    chk(key_valid == 1'b1, "start_latency_valid", key_valid, 1);
    chk(round_idx == 4'd10, "start_latency_idx", round_idx, 10);
  endtask

  task automatic wait_idle(input string nm);
    int c;
    c = 0;
    while ((q.size() != 0 || busy) && c < 400) begin
      @(posedge clk); #1;
      c++;
    end
    chk(c < 400, nm, c, 400);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk(round_key == '0 && round_idx == 4'd0 && !key_valid && !busy && !done, nm,
        {round_key[119:0], round_idx, key_valid, busy, done}, 0);
  endtask

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, b;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sb_ref[x] = b;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      key_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops on handshake, checks hold-stability, done timing and next-cycle valid.
  initial begin
    exp_t         e;
    bit           held, exp_done, exp_nv;
    logic [127:0] hk;
    logic [3:0]   hi;
    held = 0; exp_done = 0; exp_nv = 0;
    forever begin
      @(negedge clk);
      if (exp_done || done) chk(done == exp_done, "done_pulse", done, exp_done);
      if (done) done_count++;
      if (held) chk(key_valid && round_key == hk && round_idx == hi, "hold_stable",
                    {round_idx, round_key[123:0]}, {hi, hk[123:0]});
      if (exp_nv) chk(key_valid == NEXT_VLD, "next_valid", key_valid, NEXT_VLD);
      held = 0; exp_done = 0; exp_nv = 0;
      if (!rst && key_valid) begin
        if (key_ready) begin
          chk(q.size() != 0, "unexpected_key", round_idx, 0);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk(round_idx == e.idx, "round_idx", round_idx, e.idx);
            chk(round_key == e.key, $sformatf("round_key_r%0d", e.idx), round_key, e.key);
            if (e.idx == 4'd0) exp_done = 1;
            else exp_nv = 1;
          end
        end else begin
          held = 1; hk = round_key; hi = round_idx;
        end
      end
    end
  end

  initial begin
    logic [127:0] k;
    int c;
    rst = 1'b1; start = 1'b0; key_in = '0; key_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    rst = 1'b0;
    @(posedge clk); #1;

    // FIPS-197 A.1 round-10 key, always ready.
    start_seq(128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1);
    wait_idle("fips_ready_timeout");
    done_expected++;

    rdy_rand = 1'b1;
    start_seq(128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1);
    wait_idle("fips_backpressure_timeout");
    done_expected++;

    // start pulsed mid-sequence with another key must be ignored.
    rdy_rand = 1'b0;
    start_seq({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle("mid_start_timeout");
    done_expected++;

    // Reset while round 5 is presented, then a fresh full sequence.
    rdy_rand = 1'b1;
    start_seq({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    c = 0;
    while (!(key_valid && round_idx == 4'd5) && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    chk(c < 200, "reach_round5_timeout", c, 200);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("reset_mid_sequence");
    q.delete();
    rst = 1'b0;
    start_seq({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    wait_idle("after_reset_timeout");
    done_expected++;

    // Reset and start together: reset wins.
    rst = 1'b1; start = 1'b1; key_in = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    chk(!key_valid && !busy, "rst_start_same_cycle", {key_valid, busy}, 0);
    rst = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk(!key_valid && !busy, "rst_start_stays_idle", {key_valid, busy}, 0);

    for (int n = 0; n < 6; n++) begin
      rdy_rand = n[0];
      k = {$urandom, $urandom, $urandom, $urandom};
      start_seq(k, 1'b0);
      wait_idle("random_key_timeout");
      done_expected++;
    end

    @(posedge clk); #1;
    chk(done_count == done_expected, "done_count", done_count, done_expected);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_inv_key_schedule.md
Name: aes_inv_key_schedule

Overview:
- Inverse AES-128 key expansion for the decryption path.
- Loads the last round key (round 10) and walks the key schedule backwards, presenting round keys 10, 9, …, 0 one at a time.
- Each key is delivered over a valid/ready handshake to the decrypt-side round-key adder.
- Removes the need to store all 11 expanded keys: only one 128-bit key register is held.

Parameters:
- word_size, 8, bits per state byte; only 8 supported.
- array_size, 16, bytes per key; only 16 supported (AES-128).
- NUM_ROUNDS, 10, number of rounds; first index emitted equals NUM_ROUNDS.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset: synchronous, active-high; clock clk.
- start  input  1  load key_in and begin the sequence; honoured only in IDLE.
- key_in  input  word_size*array_size  round-10 key; byte k at [8k+7:8k].
- key_ready  input  1  consumer accepts round_key this cycle.
- round_key  output  word_size*array_size  current round key, same byte order as key_in.
- round_idx  output  4  round number of round_key (10..0).
- key_valid  output  1  round_key/round_idx are valid.
- busy  output  1  sequence in progress (not IDLE).
- done  output  1  one-cycle pulse after round 0 is accepted.

Behaviour:
- Byte/word order:
  - word j = bytes 4j..4j+3, byte 4j is the FIPS-197 most-significant byte.
  - word 0 = bits [31:0].
- Reset (rst=1 at posedge, any state including mid-sequence): round_key=0, round_idx=0, key_valid=0, busy=0, done=0, state=IDLE. Reset wins over start.
- States: IDLE, PRESENT, DONE (plus WAIT_SB when AES_INV_KS_SBOX_REG_EN is defined).
- IDLE:
  - start=1 → round_key<=key_in, round_idx<=NUM_ROUNDS, key_valid<=1, busy<=1, go PRESENT.
  - Latency start → key_valid is 1 cycle.
- PRESENT:
  - Holds round_key/round_idx stable while key_valid=1 and key_ready=0.
  - Handshake (key_valid&key_ready) with round_idx=r>0: round_key<=prev(round_key, r), round_idx<=r-1, key_valid stays 1. Back-to-back, one key per cycle.
  - Handshake with r=0: key_valid<=0, go DONE.
- DONE: done=1 for exactly one cycle, busy<=0, return to IDLE.
- start while busy: ignored, no effect on the sequence.
- prev(K, r), with K words w0..w3 and results p0..p3:
  - p3=w3^w2; p2=w2^w1; p1=w1^w0.
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {Rcon[r],00,00,00}.
  - RotWord: bytes (a,b,c,d) → (b,c,d,a).
  - SubWord uses the forward AES S-box (combinational table inside the block).
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- Total: 11 keys emitted per start; done follows the last handshake by 1 cycle.
- key_ready is ignored while key_valid=0.

Optional Feature:
- Macro: AES_INV_KS_SBOX_REG_EN.
- Defined:
  - SubWord output registered for timing.
  - On handshake at r>0: key_valid<=0, enter WAIT_SB for 1 cycle, then present r-1 with key_valid=1.
  - Throughput is one key per 2 cycles; key values are unchanged.
  - Reset clears the S-box pipeline register.
- Not defined: fully combinational prev(), one key per cycle, no WAIT_SB state.

Test Plan:
- FIPS-197 A.1: key_in=d014f9a8c9ee2589e13f0cc8b6630ca6 (FIPS byte order), start, key_ready=1 → round 10 = key_in, round 9 = ac7766f319fadc2128d12941575c006e, round 0 = 2b7e151628aed2a6abf7158809cf4f3c; done 1 cycle after round 0; 11 valid cycles back-to-back.
- Backpressure: key_ready random 50% → each key held stable until accepted; sequence identical to scenario 1; no index skipped or repeated.
- start pulsed mid-sequence with a different key_in → ignored; output sequence matches the original key.
- rst asserted while round_idx=5 → next cycle all outputs 0, IDLE; a new start then produces the full sequence from round 10.
- Simultaneous rst=1 and start=1 → stays IDLE, key_valid=0.
- With AES_INV_KS_SBOX_REG_EN and key_ready=1: key_valid toggles 1,0,1,0…; same 11 keys; done after round 0.
